// File: rtl/nano_sequencer.sv
// nano_sequencer: control and sequencing unit of the nanoprocessor.
// Each instruction is two bytes: an opcode byte at pc (only bits [3:0] are
// decoded) and an operand-address byte at pc+1. Every instruction runs
// FETCH -> DECODE -> ADDR -> EXEC, four cycles, and always reads its operand.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   ram_addr/we/wdata   RAM request (combinational from state and registers)
//   ram_rdata           RAM read data, one cycle after ram_addr
//   alu_i/a/b/cin       ALU inputs (opcode, acc, ram_rdata, carry)
//   alu_s/cout/z        ALU results, committed in EXEC of opcodes 0-9
//   acc, carry, zero    accumulator and C/Z flags (registered)
//   pc, halted          program counter and halt indicator (registered)
module nano_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [3:0] alu_i,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_s,
  input  logic       alu_cout,
  input  logic       alu_z,
  output logic [7:0] acc,
  output logic       carry,
  output logic       zero,
  output logic [7:0] pc,
  output logic       halted
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ROR   = 4'd9;
  localparam logic [OPW-1:0] OP_STORE = 4'd10;
  localparam logic [OPW-1:0] OP_JMP   = 4'd11;
  localparam logic [OPW-1:0] OP_JC    = 4'd12;
  localparam logic [OPW-1:0] OP_JZ    = 4'd13;
  localparam logic [OPW-1:0] OP_HALT  = 4'd14;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ADDR,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  ir_q, ir_d;
  logic [DW-1:0]   ar_q, ar_d;
  logic [DW-1:0]   pc_d, acc_d;
  logic            carry_d, zero_d, halted_d;

  // ALU wiring is fixed; the ALU is purely combinational on these.
  assign alu_i     = ir_q;
  assign alu_a     = acc;
  assign alu_b     = ram_rdata;
  assign alu_cin   = carry;
  assign ram_wdata = acc;

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      ar_q    <= '0;
      pc      <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      pc      <= pc_d;
      acc     <= acc_d;
      carry   <= carry_d;
      zero    <= zero_d;
      halted  <= halted_d;
    end
  end

  // Next-state, register updates and RAM request.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ar_d     = ar_q;
    pc_d     = pc;
    acc_d    = acc;
    carry_d  = carry;
    zero_d   = zero;
    halted_d = halted;
    ram_addr = pc;
    ram_we   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ram_addr = pc;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ir_d     = ram_rdata[OPW-1:0];
        ram_addr = pc + 8'd1;
        state_d  = S_ADDR;
      end
      S_ADDR: begin
        // Operand address goes straight to the RAM so the operand is
        // available in EXEC.
        ar_d     = ram_rdata;
        ram_addr = ram_rdata;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        ram_addr = ar_q;
        pc_d     = pc + 8'd2;
        state_d  = S_FETCH;
        if (ir_q <= OP_ROR) begin
          acc_d   = alu_s;
          carry_d = alu_cout;
          zero_d  = alu_z;
        end else begin
          case (ir_q)
            OP_STORE: ram_we = 1'b1;
            OP_JMP:   pc_d = ar_q;
            OP_JC:    if (carry) pc_d = ar_q;
            OP_JZ:    if (zero) pc_d = ar_q;
            OP_HALT: begin
              pc_d     = pc;
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_HALT: begin
        ram_addr = pc;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_nano_sequencer.sv
// Bench for nano_sequencer: behavioural RAM and ALU models, a table of
// two-instruction programs, and hand-written multi-cycle sequences.
module tb_nano_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we;
  logic [3:0] alu_i;
  logic [7:0] alu_a, alu_b, alu_s;
  logic       alu_cin, alu_cout, alu_z;
  logic [7:0] acc, pc;
  logic       carry, zero, halted;

  int n_cmp = 0;
  int n_err = 0;

  // RAM model with a load port used while the DUT is held in reset.
  logic [7:0] mem [256];
  logic       clr, ld_en;
  logic [7:0] ld_addr, ld_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'h0E;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ALU reference: bit 8 is carry-out (borrow for subtraction).
  logic [8:0] r;
  always_comb begin
    r = '0;
    case (alu_i)
      4'd0: r = {1'b0, alu_b};
      4'd1: r = {1'b0, alu_a ^ alu_b};
      4'd2: r = {1'b0, alu_a & alu_b};
      4'd3: r = {1'b0, alu_a | alu_b};
      4'd4: r = {1'b0, alu_a} + {1'b0, alu_b};
      4'd5: r = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      4'd6: r = {1'b0, alu_a} - {1'b0, alu_b};
      4'd7: r = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
      4'd8: r = {alu_a[7], alu_a[6:0], alu_cin};
      4'd9: r = {alu_a[0], alu_cin, alu_a[7:1]};
      default: r = {1'b0, alu_a};
    endcase
  end
  assign alu_s    = r[7:0];
  assign alu_cout = r[8];
  assign alu_z    = ~|r[7:0];

  nano_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .alu_i(alu_i), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_cout(alu_cout), .alu_z(alu_z),
    .acc(acc), .carry(carry), .zero(zero), .pc(pc), .halted(halted)
  );

  typedef struct {
    logic [7:0] op0, op1, ar1, d0, d1;
    logic [7:0] e_acc;
    logic       e_c, e_z;
    logic [7:0] e_pc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Hold reset and fill memory with HALT opcodes.
  task automatic begin_test();
    reset_n = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // 00:LOAD 20, 02:LOAD 5A->STORE 30, 04:LOAD 21 (0x00), 06:LOAD 30, 08:HALT
  task automatic load_store_prog();
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h20);
    poke(8'h02, 8'h0A); poke(8'h03, 8'h30);
    poke(8'h04, 8'h00); poke(8'h05, 8'h21);
    poke(8'h06, 8'h00); poke(8'h07, 8'h30);
    poke(8'h20, 8'h5A); poke(8'h21, 8'h00);
  endtask

  initial begin
    int we_cnt;
    reset_n = 1'b0; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    //           op0    op1    ar1    d0     d1     acc    c     z     pc
    vecs[0]  = '{8'h00, 8'h04, 8'h21, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 8'h04}; // ADD
    vecs[1]  = '{8'h00, 8'h01, 8'h21, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 8'h04}; // XOR
    vecs[2]  = '{8'h00, 8'h02, 8'h21, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 8'h04}; // AND
    vecs[3]  = '{8'h00, 8'h03, 8'h21, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 8'h04}; // OR
    vecs[4]  = '{8'h00, 8'h04, 8'h21, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 8'h04}; // ADD wrap
    vecs[5]  = '{8'h00, 8'h06, 8'h21, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 8'h04}; // SUB borrow
    vecs[6]  = '{8'h00, 8'h0D, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h40}; // JZ taken
    vecs[7]  = '{8'h00, 8'h0D, 8'h40, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 8'h04}; // JZ not
    vecs[8]  = '{8'h00, 8'h08, 8'h21, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 8'h04}; // ROL
    vecs[9]  = '{8'h00, 8'h0C, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h04}; // JC not
    vecs[10] = '{8'h00, 8'h0B, 8'h40, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 8'h40}; // JMP
    vecs[11] = '{8'h00, 8'h0F, 8'h21, 8'h33, 8'h00, 8'h33, 1'b0, 1'b0, 8'h04}; // NOP
    vecs[12] = '{8'h00, 8'h05, 8'h21, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 8'h04}; // ADC
    vecs[13] = '{8'h00, 8'h07, 8'h21, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 8'h04}; // SBC
    vecs[14] = '{8'hA0, 8'hF4, 8'h21, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 8'h04}; // high nibble ignored

    // Table: two instructions then HALT; halt reached on edge 12.
    for (int i = 0; i < NV; i++) begin
      begin_test();
      poke(8'h00, vecs[i].op0); poke(8'h01, 8'h20);
      poke(8'h02, vecs[i].op1); poke(8'h03, vecs[i].ar1);
      poke(8'h20, vecs[i].d0);  poke(8'h21, vecs[i].d1);
      reset_n = 1'b1;
      repeat (11) step();
      chk($sformatf("v%0d halted@11", i), 8'(halted), 8'h00);
      step();
      chk($sformatf("v%0d halted@12", i), 8'(halted), 8'h01);
      chk($sformatf("v%0d acc", i), acc, vecs[i].e_acc);
      chk($sformatf("v%0d carry", i), 8'(carry), 8'(vecs[i].e_c));
      chk($sformatf("v%0d zero", i), 8'(zero), 8'(vecs[i].e_z));
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
    end

    // Basic program, reset state, per-instruction timing, halt persistence.
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h20); poke(8'h02, 8'h04); poke(8'h03, 8'h21);
    poke(8'h04, 8'h0E); poke(8'h05, 8'h00); poke(8'h20, 8'h05); poke(8'h21, 8'h03);
    chk("rst acc", acc, 8'h00);
    chk("rst pc", pc, 8'h00);
    chk("rst carry", 8'(carry), 8'h00);
    chk("rst zero", 8'(zero), 8'h00);
    chk("rst halted", 8'(halted), 8'h00);
    chk("rst ram_addr", ram_addr, 8'h00);
    chk("rst ram_we", 8'(ram_we), 8'h00);
    chk("rst ram_wdata", ram_wdata, 8'h00);
    chk("rst alu_i", 8'(alu_i), 8'h00);
    chk("rst alu_a", alu_a, 8'h00);
    chk("rst alu_cin", 8'(alu_cin), 8'h00);
    chk("rst alu_b", alu_b, ram_rdata);
    reset_n = 1'b1;
    repeat (3) step();
    chk("p1 acc@3", acc, 8'h00);
    step();
    chk("p1 acc@4", acc, 8'h05);
    repeat (4) step();
    chk("p1 acc@8", acc, 8'h08);
    chk("p1 carry@8", 8'(carry), 8'h00);
    repeat (3) step();
    chk("p1 halted@11", 8'(halted), 8'h00);
    step();
    chk("p1 halted@12", 8'(halted), 8'h01);
    repeat (6) step();
    chk("p1 halted@18", 8'(halted), 8'h01);
    chk("p1 pc", pc, 8'h04);
    chk("p1 ram_addr halt", ram_addr, 8'h04);
    chk("p1 ram_we halt", 8'(ram_we), 8'h00);

    // LOAD FF, ADD 01, ADC 00.
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h20); poke(8'h02, 8'h04); poke(8'h03, 8'h21);
    poke(8'h04, 8'h05); poke(8'h05, 8'h22);
    poke(8'h20, 8'hFF); poke(8'h21, 8'h01); poke(8'h22, 8'h00);
    reset_n = 1'b1;
    repeat (8) step();
    chk("add acc", acc, 8'h00);
    chk("add carry", 8'(carry), 8'h01);
    chk("add zero", 8'(zero), 8'h01);
    repeat (4) step();
    chk("adc acc", acc, 8'h01);
    chk("adc carry", 8'(carry), 8'h00);
    chk("adc zero", 8'(zero), 8'h00);

    // LOAD 81, ROL, ROR.
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h20); poke(8'h02, 8'h08); poke(8'h03, 8'h20);
    poke(8'h04, 8'h09); poke(8'h05, 8'h20); poke(8'h20, 8'h81);
    reset_n = 1'b1;
    repeat (8) step();
    chk("rol acc", acc, 8'h02);
    chk("rol carry", 8'(carry), 8'h01);
    repeat (4) step();
    chk("ror acc", acc, 8'h81);
    chk("ror carry", 8'(carry), 8'h00);

    // Store then reload the stored location.
    load_store_prog();
    reset_n = 1'b1;
    we_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (ram_we) we_cnt++;
      if (c == 7) begin
        chk("st we", 8'(ram_we), 8'h01);
        chk("st addr", ram_addr, 8'h30);
        chk("st wdata", ram_wdata, 8'h5A);
      end
      if (c == 8) chk("st we drop", 8'(ram_we), 8'h00);
      if (c == 12) chk("st acc cleared", acc, 8'h00);
    end
    chk("st we pulses", 8'(we_cnt), 8'h01);
    chk("st mem", mem[8'h30], 8'h5A);
    chk("st reload acc", acc, 8'h5A);

    // Wrap: JMP FF; opcode at FF takes its operand address from 00.
    begin_test();
    poke(8'h00, 8'h0B); poke(8'h01, 8'hFF); poke(8'hFF, 8'h00); poke(8'h0B, 8'h77);
    reset_n = 1'b1;
    repeat (8) step();
    chk("wrap acc", acc, 8'h77);
    chk("wrap pc", pc, 8'h01);
    repeat (8) step();
    chk("wrap halted", 8'(halted), 8'h01);
    chk("wrap pc halt", pc, 8'h03);

    // Reset asserted during EXEC of the STORE.
    load_store_prog();
    reset_n = 1'b1;
    repeat (7) step();
    chk("rs we before", 8'(ram_we), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("rs we async", 8'(ram_we), 8'h00);
    chk("rs acc", acc, 8'h00);
    chk("rs pc", pc, 8'h00);
    chk("rs ram_addr", ram_addr, 8'h00);
    chk("rs halted", 8'(halted), 8'h00);
    step();
    chk("rs mem untouched", mem[8'h30], 8'h0E);
    reset_n = 1'b1;
    chk("rs fetch addr", ram_addr, 8'h00);
    step();
    chk("rs decode addr", ram_addr, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nano_sequencer.md
# nano_sequencer

Control and sequencing unit of the nanoprocessor. It fetches two-byte instructions from the synchronous data/program RAM, drives the ALU's instruction, operand and carry-in inputs, and registers the ALU results into the accumulator and the C/Z flags. It also handles stores and conditional jumps. It is the counterpart of the combinational ALU: it produces everything the ALU consumes and consumes everything the ALU produces.

## Interface
Parameters: none; data and address widths are fixed at 8 bits.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ram_addr  out  8  RAM address; combinational from state and registers.
- ram_we  out  1  RAM write enable; high only in EXEC of STORE.
- ram_wdata  out  8  RAM write data; always equals acc.
- ram_rdata  in  8  RAM read data; valid one cycle after ram_addr is presented.
- alu_i  out  4  ALU opcode; equals ir[3:0].
- alu_a  out  8  ALU operand A; equals acc.
- alu_b  out  8  ALU operand B; equals ram_rdata.
- alu_cin  out  1  ALU carry-in; equals carry.
- alu_s  in  8  ALU result.
- alu_cout  in  1  ALU carry-out.
- alu_z  in  1  ALU zero flag (1 when alu_s is 0).
- acc  out  8  accumulator.
- carry  out  1  C flag.
- zero  out  1  Z flag.
- pc  out  8  program counter.
- halted  out  1  high while the FSM is in HALT.

## Operation
- Instruction format: byte at pc is the opcode (only bits [3:0] are used, bits [7:4] are ignored). Byte at pc+1 is the operand address AR.
- Opcodes 0–9 are ALU operations, with acc <= alu_s, carry <= alu_cout, zero <= alu_z:
  - 0 LOAD, 1 XOR, 2 AND, 3 OR, 4 ADD, 5 ADC, 6 SUB, 7 SBC, 8 ROL through carry, 9 ROR through carry.
  - LOAD and the logic ops clear carry, because the ALU returns Cout=0 for them.
- Opcode 10 STORE: mem[AR] <= acc. Flags unchanged.
- Opcode 11 JMP: pc <= AR.
- Opcode 12 JC: pc <= AR if carry=1, else pc <= pc+2.
- Opcode 13 JZ: pc <= AR if zero=1, else pc <= pc+2.
- Opcode 14 HALT: enter HALT.
- Opcode 15 NOP: no effect except pc <= pc+2.
- FSM states and transitions:
  - FETCH: ram_addr=pc; next state DECODE.
  - DECODE: ir <= ram_rdata; ram_addr=pc+1; next state ADDR.
  - ADDR: ar <= ram_rdata; ram_addr=ram_rdata, which starts the operand read; next state EXEC.
  - EXEC: ram_addr=ar. ALU results are committed, or the store/jump is performed. pc <= pc+2 unless a jump is taken. Next state is FETCH, or HALT for opcode 14.
  - HALT: ram_addr=pc, ram_we=0, all registers hold. Left only by reset.
- acc, carry and zero are written only in EXEC of opcodes 0–9.
- Arithmetic: pc and pc+1 are mod 256. Opcode at 0xFF takes its operand address from 0x00. pc 0xFE + 2 = 0x00.
- The operand is always read, even for STORE, jumps and NOP, so every instruction has uniform timing.

## Timing
- Reset values: acc=0x00, carry=0, zero=0, pc=0x00, ir=0x00, ar=0x00, state=FETCH, halted=0.
- Combinational outputs take their reset-state values:
  - ram_we=0, ram_addr=0x00, ram_wdata=0x00.
  - alu_i=0, alu_a=0x00, alu_cin=0.
  - alu_b follows ram_rdata at all times.
- Every instruction takes exactly 4 cycles (FETCH..EXEC). HALT takes 4 cycles to reach the HALT state.
- An ALU result is visible on acc, carry and zero the cycle after EXEC. That cycle is the next FETCH.
- STORE: ram_we is high for exactly the one EXEC cycle, with ram_addr=ar and ram_wdata=acc.
- Reset mid-operation: assertion takes effect immediately and asynchronously.
  - ram_we drops without waiting for a clock edge; a store in flight is aborted.
  - After release, the first FETCH occurs on the first rising edge.
- A read of the same address just stored returns the new value on the next instruction (RAM write-first not required).

## Test plan
- RAM {00:00 01:20 02:04 03:21 04:0E 05:00 20:05 21:03}. Required: acc=0x05 after the first instruction, then acc=0x08 with carry=0. halted=1 at cycle 12 and stays set. pc=0x04 in HALT.
- ADD 0xFF+0x01 then ADC 0x00+0x00. Required: after ADD acc=0x00, carry=1, zero=1. After ADC acc=0x01, carry=0, zero=0.
- LOAD 0x00 then JZ 0x40. Required: pc=0x40 after EXEC. Repeat with loaded 0x01: pc=0x04 instead.
- LOAD 0x5A then STORE 0x30. Required: ram_we pulses one cycle with ram_addr=0x30 and ram_wdata=0x5A. A following LOAD 0x30 returns 0x5A.
- ROL of 0x81 with carry=0. Required: acc=0x02, carry=1. Then ROR: acc=0x81, carry=0.
- Assert reset_n during EXEC of a STORE. Required: ram_we falls the same cycle with no clock edge. All registers return to reset values. The first FETCH after release uses ram_addr=0x00.
